// File: rtl/rr_trace_buf_sched_if.sv
`default_nettype none
//----------------------------------------------------------------------------
// rr_trace_buf_sched_if : CSR and writeback-engine signal bundle for
// rr_trace_buf_sched. Stats ports exist only with RR_BUF_SCHED_STATS_EN.
// Rev 1.0
//----------------------------------------------------------------------------
interface rr_trace_buf_sched_if #(
   parameter int DESC_DEPTH = 4,
   parameter int ADDR_WIDTH = 64,
   parameter int SIZE_WIDTH = 32
);
   localparam int c_CNT_W = $clog2(DESC_DEPTH + 1);

   logic                  csr_enable;
   logic                  csr_desc_valid;
   logic [ADDR_WIDTH-1:0] csr_desc_addr;
   logic [SIZE_WIDTH-1:0] csr_desc_size;
   logic                  csr_finish_req;
   logic                  wb_buf_done;
   logic                  wb_idle;
   logic [ADDR_WIDTH-1:0] wb_buf_addr;
   logic [SIZE_WIDTH-1:0] wb_buf_size;
   logic                  wb_buf_update;
   logic                  wb_finish;
   logic [c_CNT_W-1:0]    desc_count;
   logic                  desc_overflow;
   logic                  irq_buf;
   logic                  irq_done;
   logic [2:0]            state_o;
`ifdef RR_BUF_SCHED_STATS_EN
   logic [31:0]           stat_bufs_retired;
   logic [31:0]           stat_starve_cycles;
   logic [15:0]           stat_drain_cycles;
`endif

   modport slave (
`ifdef RR_BUF_SCHED_STATS_EN
      output stat_bufs_retired, stat_starve_cycles, stat_drain_cycles,
`endif
      input  csr_enable, csr_desc_valid, csr_desc_addr, csr_desc_size,
      input  csr_finish_req, wb_buf_done, wb_idle,
      output wb_buf_addr, wb_buf_size, wb_buf_update, wb_finish,
      output desc_count, desc_overflow, irq_buf, irq_done, state_o
   );

   modport master (
`ifdef RR_BUF_SCHED_STATS_EN
      input  stat_bufs_retired, stat_starve_cycles, stat_drain_cycles,
`endif
      output csr_enable, csr_desc_valid, csr_desc_addr, csr_desc_size,
      output csr_finish_req, wb_buf_done, wb_idle,
      input  wb_buf_addr, wb_buf_size, wb_buf_update, wb_finish,
      input  desc_count, desc_overflow, irq_buf, irq_done, state_o
   );
endinterface

`default_nettype wire

// File: rtl/rr_trace_buf_sched.sv
`default_nettype none
//----------------------------------------------------------------------------
// rr_trace_buf_sched : trace buffer descriptor queue and writeback sequencer
// with finish/drain handshake. Optional counters: RR_BUF_SCHED_STATS_EN.
// Rev 1.0
//----------------------------------------------------------------------------
module rr_trace_buf_sched #(
   parameter int DESC_DEPTH = 4,
   parameter int ADDR_WIDTH = 64,
   parameter int SIZE_WIDTH = 32
) (
   input  logic                clk,
   input  logic                rstn,
   rr_trace_buf_sched_if.slave bus
);
   localparam int c_PTR_W = $clog2(DESC_DEPTH);
   localparam int c_CNT_W = $clog2(DESC_DEPTH + 1);
   localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DESC_DEPTH);

   localparam logic [2:0] c_IDLE    = 3'd0;
   localparam logic [2:0] c_LOAD    = 3'd1;
   localparam logic [2:0] c_ACTIVE  = 3'd2;
   localparam logic [2:0] c_STARVED = 3'd3;
   localparam logic [2:0] c_DRAIN   = 3'd4;
   localparam logic [2:0] c_DONE    = 3'd5;

   logic [ADDR_WIDTH-1:0] r_mem_addr [DESC_DEPTH];
   logic [SIZE_WIDTH-1:0] r_mem_size [DESC_DEPTH];
   logic [c_PTR_W-1:0]    r_wr_ptr;
   logic [c_PTR_W-1:0]    r_rd_ptr;
   logic [c_CNT_W-1:0]    r_count;
   logic [2:0]            r_state;
   logic [2:0]            w_next;
   logic                  r_en_q;
   logic                  r_overflow;
   logic                  r_irq_buf;
   logic                  r_update;
   logic                  r_idle_seen;
   logic [ADDR_WIDTH-1:0] r_buf_addr;
   logic [SIZE_WIDTH-1:0] r_buf_size;

   logic w_size_ok;
   logic w_abort;
   logic w_flush;
   logic w_pop;
   logic w_room;
   logic w_push;
   logic w_ovf;
   logic w_avail;
   logic w_done_in;

   assign w_size_ok = (bus.csr_desc_size != '0) && (bus.csr_desc_size[5:0] == 6'd0);
   assign w_abort   = !bus.csr_enable && (r_state != c_IDLE) && (r_state != c_DONE);
   assign w_flush   = w_abort || ((r_state == c_DONE) && !bus.csr_enable);
   assign w_pop     = (r_state == c_LOAD) && !w_abort && (r_count != '0);
   // A pop in the same cycle frees the slot a full-queue push needs.
   assign w_room    = (r_count != c_FULL) || w_pop;
   assign w_push    = bus.csr_desc_valid && w_size_ok && w_room && !w_flush;
   assign w_ovf     = bus.csr_desc_valid && (!w_size_ok || !w_room);
   assign w_avail   = (r_count != '0) || w_push;
   assign w_done_in = bus.wb_buf_done && !w_abort &&
                      ((r_state == c_ACTIVE) || (r_state == c_DRAIN));

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_IDLE:    if (bus.csr_enable) w_next = w_avail ? c_LOAD : c_STARVED;
         c_LOAD:    w_next = c_ACTIVE;
         c_ACTIVE: begin
            if (bus.csr_finish_req)   w_next = c_DRAIN;
            else if (bus.wb_buf_done) w_next = w_avail ? c_LOAD : c_STARVED;
         end
         c_STARVED: begin
            if (bus.csr_finish_req)   w_next = c_DRAIN;
            else if (w_avail)         w_next = c_LOAD;
         end
         c_DRAIN:   if (bus.wb_idle && r_idle_seen) w_next = c_DONE;
         c_DONE:    if (!bus.csr_enable) w_next = c_IDLE;
         default:   w_next = c_IDLE;
      endcase
      if (w_abort) w_next = c_IDLE;
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_addr[r_wr_ptr] <= bus.csr_desc_addr;
         r_mem_size[r_wr_ptr] <= bus.csr_desc_size;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= c_IDLE;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_en_q      <= 1'b0;
         r_overflow  <= 1'b0;
         r_irq_buf   <= 1'b0;
         r_update    <= 1'b0;
         r_idle_seen <= 1'b0;
         r_buf_addr  <= '0;
         r_buf_size  <= '0;
      end else begin
         r_state     <= w_next;
         r_en_q      <= bus.csr_enable;
         r_irq_buf   <= w_done_in;
         r_update    <= w_pop;
         r_idle_seen <= (r_state == c_DRAIN) && bus.wb_idle && !w_abort;
         if (w_pop) begin
            r_buf_addr <= r_mem_addr[r_rd_ptr];
            r_buf_size <= r_mem_size[r_rd_ptr];
         end
         if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
         end
         if (w_ovf)                           r_overflow <= 1'b1;
         else if (r_en_q && !bus.csr_enable)  r_overflow <= 1'b0;
      end
   end

   assign bus.wb_buf_addr   = r_buf_addr;
   assign bus.wb_buf_size   = r_buf_size;
   assign bus.wb_buf_update = r_update;
   assign bus.wb_finish     = (r_state == c_DRAIN);
   assign bus.desc_count    = r_count;
   assign bus.desc_overflow = r_overflow;
   assign bus.irq_buf       = r_irq_buf;
   assign bus.irq_done      = (r_state == c_DONE);
   assign bus.state_o       = r_state;

`ifdef RR_BUF_SCHED_STATS_EN
   logic [31:0] r_stat_bufs;
   logic [31:0] r_stat_starve;
   logic [15:0] r_stat_drain;
   logic        w_en_rise;

   assign w_en_rise = bus.csr_enable && !r_en_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_stat_bufs   <= '0;
         r_stat_starve <= '0;
         r_stat_drain  <= '0;
      end else if (w_en_rise) begin
         r_stat_bufs   <= '0;
         r_stat_starve <= '0;
         r_stat_drain  <= '0;
      end else begin
         if (w_done_in)              r_stat_bufs   <= r_stat_bufs + 32'd1;
         if (r_state == c_STARVED)   r_stat_starve <= r_stat_starve + 32'd1;
         if ((r_state == c_DRAIN) && (r_stat_drain != 16'hFFFF))
            r_stat_drain <= r_stat_drain + 16'd1;
      end
   end

   assign bus.stat_bufs_retired  = r_stat_bufs;
   assign bus.stat_starve_cycles = r_stat_starve;
   assign bus.stat_drain_cycles  = r_stat_drain;
`endif
endmodule

`default_nettype wire
